power_sequencer: RTL and testbench
==================================

POWER_SEQUENCER -- requirements
Module: power_sequencer

Interface
REQ-001 SHALL have parameter C_RAIL_QTY, default 5, number of sequenced supply rails (1..16).
REQ-002 SHALL have parameter C_PG_TIMEOUT, default 4000, max cycles to wait for one rail's PGOOD.
REQ-003 SHALL have parameter C_STEP_DELAY, default 400, settle cycles between rail steps (>=1).
REQ-004 CLK_IN  in  1  system clock; all logic on rising edge, single clock domain.
REQ-005 RST_N_IN  in  1  reset; synchronous, active-low.
REQ-006 START_IN  in  1  level; 1 = power up requested, 0 = orderly power down.
REQ-007 CLEAR_IN  in  1  single-cycle pulse; clears latched fault.
REQ-008 TEMP_ALARM_IN  in  1  over-temperature flag from temperature sensor reader, synchronous to CLK_IN.
REQ-009 PGOOD_bus_IN  in  C_RAIL_QTY  per-rail power-good, 1 = ok; synchronised externally.
REQ-010 EN_bus_OUT  out  C_RAIL_QTY  per-rail enable, registered, bit 0 enabled first.
REQ-011 FPGA_PROG_B_OUT  out  1  FPGA configuration release, 0 = hold FPGA in reset.
REQ-012 STATE_OUT  out  3  current state encoding, for LED status.
REQ-013 FAULT_OUT  out  1  latched fault flag.
REQ-014 FAULT_CODE_OUT  out  2  0 none, 1 PGOOD timeout, 2 PGOOD loss, 3 over-temp.
REQ-015 FAULT_RAIL_OUT  out  4  index of failing rail (0 for over-temp).

Function
REQ-016 SHALL implement states IDLE, WAIT_PG, SETTLE, RUN, SHUTDOWN, FAULT.
REQ-017 IDLE: all EN 0, PROG_B 0; START_IN=1 and FAULT_OUT=0 -> WAIT_PG with rail index i=0, EN[0]=1 on the next cycle.
REQ-018 WAIT_PG: cycle counter increments; PGOOD[i]=1 -> SETTLE, counter cleared; counter reaches C_PG_TIMEOUT-1 with PGOOD[i]=0 -> SHUTDOWN, fault code 1, rail i.
REQ-019 SETTLE: after exactly C_STEP_DELAY cycles, i<C_RAIL_QTY-1 -> i+1, EN[i+1]=1, WAIT_PG; i=C_RAIL_QTY-1 -> RUN.
REQ-020 RUN: FPGA_PROG_B_OUT=1 from the first RUN cycle; all EN remain 1.
REQ-021 In WAIT_PG, SETTLE, RUN any already-acknowledged rail (index < i, or <= i after ack) dropping PGOOD -> SHUTDOWN, fault code 2, lowest such rail index.
REQ-022 In any state except IDLE, FAULT, SHUTDOWN, TEMP_ALARM_IN=1 -> SHUTDOWN, fault code 3 (when enabled, see Configuration).
REQ-023 Simultaneous events priority: PGOOD loss > timeout > over-temp > START_IN=0.
REQ-024 START_IN=0 in WAIT_PG, SETTLE or RUN -> SHUTDOWN with no fault.
REQ-025 SHUTDOWN: PROG_B=0 on entry cycle; highest enabled rail cleared immediately, then one further rail cleared every C_STEP_DELAY cycles, reverse order; after EN all 0 -> FAULT if fault latched, else IDLE.
REQ-026 Faults in SHUTDOWN are ignored; START_IN changes in SHUTDOWN are ignored.
REQ-027 FAULT: EN all 0, PROG_B 0; CLEAR_IN=1 -> IDLE, FAULT_OUT, FAULT_CODE_OUT, FAULT_RAIL_OUT cleared same edge; START_IN ignored.
REQ-028 Fault flag, code, rail latch on the first fault only; a single shared counter sized $clog2(max(C_PG_TIMEOUT,C_STEP_DELAY)+1) bits SHALL not wrap.

Reset
REQ-029 RST_N_IN=0 at a clock edge SHALL force IDLE, EN_bus_OUT=0, FPGA_PROG_B_OUT=0, fault outputs 0, counter 0, i=0, including mid-sequence (rails drop at once).

Configuration
REQ-030 Macro POWER_SEQ_TEMP_SHUTDOWN_EN defined: TEMP_ALARM_IN behaves per REQ-022; undefined: TEMP_ALARM_IN is ignored and fault code 3 is never produced.

Structure
REQ-031 Shared package power_seq_pkg SHALL hold the state enum, STATE_OUT encodings and fault code constants.
REQ-032 Counter and compare logic SHALL be a sub-module power_seq_timer (load/clear, enable, terminal-count flag).

Verification (C_RAIL_QTY=5, C_PG_TIMEOUT=8, C_STEP_DELAY=4)
REQ-033 START_IN=1, each PGOOD returns 2 cycles after its EN -> EN 00001..11111 in order, PROG_B=1 in RUN, FAULT_OUT=0.
REQ-034 PGOOD[2] held 0 -> after 8 cycles in WAIT_PG, SHUTDOWN, EN cleared 00011->00001->00000 every 4 cycles, FAULT, code 1, rail 2.
REQ-035 In RUN, PGOOD[3] and TEMP_ALARM_IN drop/rise same cycle -> code 2, rail 3; CLEAR_IN pulse -> IDLE.
REQ-036 In RUN, TEMP_ALARM_IN=1 -> code 3 with macro defined; no effect with macro undefined.
REQ-037 RST_N_IN=0 during SETTLE of rail 1 -> next edge EN=00000, PROG_B=0, IDLE; START_IN=0 in RUN -> orderly shutdown to IDLE, FAULT_OUT=0.

Source files
------------

// File: rtl/power_seq_pkg.sv
// Shared definitions for the power sequencer: state encodings (also driven
// onto STATE_OUT for the status LEDs), fault codes and counter sizing.
package power_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PG  = 3'd1,
    S_SETTLE   = 3'd2,
    S_RUN      = 3'd3,
    S_SHUTDOWN = 3'd4,
    S_FAULT    = 3'd5
  } seq_state_t;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_PG_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_PG_LOSS    = 2'd2;
  localparam logic [1:0] FC_OVER_TEMP  = 2'd3;

  // Width of one counter able to reach the larger of the two intervals.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/power_seq_timer.sv
// Shared interval counter for the power sequencer: synchronous clear,
// count enable, saturates at all-ones, flags when the count equals term.
module power_seq_timer #(
  parameter int unsigned C_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [C_WIDTH-1:0] term,
  output logic               tc
);

  logic [C_WIDTH-1:0] count;

  // Count up while enabled; clear has priority; never wraps past all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + C_WIDTH'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/power_sequencer.sv
// Multi-rail power sequencer: enables rails in ascending order, waits for
// each PGOOD then a settle interval, releases FPGA PROG_B in RUN, and powers
// down in reverse order on request or fault, latching the first fault.
// Optional feature: define POWER_SEQ_TEMP_SHUTDOWN_EN to make TEMP_ALARM_IN
// trigger an over-temperature shutdown (fault code 3); otherwise it is ignored.
module power_sequencer
  import power_seq_pkg::*;
#(
  parameter int unsigned C_RAIL_QTY   = 5,
  parameter int unsigned C_PG_TIMEOUT = 4000,
  parameter int unsigned C_STEP_DELAY = 400
) (
  input  logic                  CLK_IN,
  input  logic                  RST_N_IN,
  input  logic                  START_IN,
  input  logic                  CLEAR_IN,
  input  logic                  TEMP_ALARM_IN,
  input  logic [C_RAIL_QTY-1:0] PGOOD_bus_IN,
  output logic [C_RAIL_QTY-1:0] EN_bus_OUT,
  output logic                  FPGA_PROG_B_OUT,
  output logic [2:0]            STATE_OUT,
  output logic                  FAULT_OUT,
  output logic [1:0]            FAULT_CODE_OUT,
  output logic [3:0]            FAULT_RAIL_OUT
);

  localparam int unsigned        C_CNT_W     = cnt_width(C_PG_TIMEOUT, C_STEP_DELAY);
  localparam logic [C_CNT_W-1:0] C_PG_TERM   = C_CNT_W'(C_PG_TIMEOUT - 1);
  localparam logic [C_CNT_W-1:0] C_STEP_TERM = C_CNT_W'(C_STEP_DELAY - 1);

  seq_state_t            state_q, state_d;
  logic [C_RAIL_QTY-1:0] en_q, en_d;
  logic [3:0]            idx_q, idx_d;
  logic                  prog_b_q;
  logic                  fault_q, fault_d;
  logic [1:0]            code_q, code_d;
  logic [3:0]            rail_q, rail_d;

  logic                  tmr_clear, tmr_en, tmr_tc;
  logic [C_CNT_W-1:0]    tmr_term;

  logic [C_RAIL_QTY-1:0] cur_mask, ack_mask, loss_vec, top_mask, en_top_off;
  logic [3:0]            loss_idx;
  logic                  loss, pg_cur, at_last, temp_trip;

  logic                  down;
  logic [1:0]            down_code;
  logic [3:0]            down_rail;

`ifdef POWER_SEQ_TEMP_SHUTDOWN_EN
  assign temp_trip = TEMP_ALARM_IN;
`else
  logic temp_unused;
  assign temp_trip   = 1'b0;
  assign temp_unused = TEMP_ALARM_IN;
`endif

  // One counter serves both the PGOOD timeout and the step/settle interval.
  assign tmr_term = (state_q == S_WAIT_PG) ? C_PG_TERM : C_STEP_TERM;

  power_seq_timer #(
    .C_WIDTH(C_CNT_W)
  ) u_timer (
    .clk   (CLK_IN),
    .rst_n (RST_N_IN),
    .clear (tmr_clear),
    .enable(tmr_en),
    .term  (tmr_term),
    .tc    (tmr_tc)
  );

  // Rail bookkeeping: current rail, acknowledged rails, lowest lost rail and
  // the enable vector with its highest enabled rail removed.
  always_comb begin
    cur_mask = '0;
    ack_mask = '0;
    top_mask = '0;
    loss_idx = '0;
    for (int unsigned k = 0; k < C_RAIL_QTY; k++) begin
      if (k == 32'(idx_q)) begin
        cur_mask[k] = 1'b1;
      end
      // The current rail counts as acknowledged once WAIT_PG has been left.
      if ((k < 32'(idx_q)) || ((k == 32'(idx_q)) && (state_q != S_WAIT_PG))) begin
        ack_mask[k] = 1'b1;
      end
      if (en_q[k]) begin
        top_mask    = '0;
        top_mask[k] = 1'b1;
      end
    end
    loss_vec = ack_mask & ~PGOOD_bus_IN;
    for (int unsigned k = C_RAIL_QTY; k > 0; k--) begin
      if (loss_vec[k-1]) begin
        loss_idx = 4'(k - 1);
      end
    end
    loss       = |loss_vec;
    pg_cur     = |(PGOOD_bus_IN & cur_mask);
    at_last    = (32'(idx_q) == (C_RAIL_QTY - 1));
    en_top_off = en_q & ~top_mask;
  end

  // Next-state, enable, fault-latch and timer control.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    idx_d     = idx_q;
    fault_d   = fault_q;
    code_d    = code_q;
    rail_d    = rail_q;
    tmr_clear = 1'b1;
    tmr_en    = 1'b0;
    down      = 1'b0;
    down_code = FC_NONE;
    down_rail = '0;

    case (state_q)
      S_IDLE: begin
        en_d  = '0;
        idx_d = '0;
        if (START_IN && !fault_q) begin
          state_d = S_WAIT_PG;
          en_d[0] = 1'b1;
        end
      end

      S_WAIT_PG: begin
        if (loss) begin
          down      = 1'b1;
          down_code = FC_PG_LOSS;
          down_rail = loss_idx;
        end else if (tmr_tc && !pg_cur) begin
          down      = 1'b1;
          down_code = FC_PG_TIMEOUT;
          down_rail = idx_q;
        end else if (temp_trip) begin
          down      = 1'b1;
          down_code = FC_OVER_TEMP;
        end else if (!START_IN) begin
          down = 1'b1;
        end else if (pg_cur) begin
          state_d = S_SETTLE;
        end else begin
          tmr_clear = 1'b0;
          tmr_en    = 1'b1;
        end
      end

      S_SETTLE: begin
        if (loss) begin
          down      = 1'b1;
          down_code = FC_PG_LOSS;
          down_rail = loss_idx;
        end else if (temp_trip) begin
          down      = 1'b1;
          down_code = FC_OVER_TEMP;
        end else if (!START_IN) begin
          down = 1'b1;
        end else if (tmr_tc) begin
          if (at_last) begin
            state_d = S_RUN;
          end else begin
            state_d = S_WAIT_PG;
            idx_d   = idx_q + 4'd1;
            en_d    = en_q | (cur_mask << 1);
          end
        end else begin
          tmr_clear = 1'b0;
          tmr_en    = 1'b1;
        end
      end

      S_RUN: begin
        if (loss) begin
          down      = 1'b1;
          down_code = FC_PG_LOSS;
          down_rail = loss_idx;
        end else if (temp_trip) begin
          down      = 1'b1;
          down_code = FC_OVER_TEMP;
        end else if (!START_IN) begin
          down = 1'b1;
        end
      end

      S_SHUTDOWN: begin
        if (en_q == '0) begin
          state_d = fault_q ? S_FAULT : S_IDLE;
        end else if (tmr_tc) begin
          en_d = en_top_off;
        end else begin
          tmr_clear = 1'b0;
          tmr_en    = 1'b1;
        end
      end

      S_FAULT: begin
        en_d = '0;
        if (CLEAR_IN) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          rail_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        en_d    = '0;
      end
    endcase

    // Every shutdown entry drops the highest rail on the same edge.
    if (down) begin
      state_d = S_SHUTDOWN;
      en_d    = en_top_off;
      if ((down_code != FC_NONE) && !fault_q) begin
        fault_d = 1'b1;
        code_d  = down_code;
        rail_d  = down_rail;
      end
    end
  end

  // State and output registers; reset drops all rails immediately.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      state_q  <= S_IDLE;
      en_q     <= '0;
      idx_q    <= '0;
      prog_b_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
      rail_q   <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      idx_q    <= idx_d;
      prog_b_q <= (state_d == S_RUN);
      fault_q  <= fault_d;
      code_q   <= code_d;
      rail_q   <= rail_d;
    end
  end

  assign EN_bus_OUT      = en_q;
  assign FPGA_PROG_B_OUT = prog_b_q;
  assign STATE_OUT       = state_q;
  assign FAULT_OUT       = fault_q;
  assign FAULT_CODE_OUT  = code_q;
  assign FAULT_RAIL_OUT  = rail_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer (5 rails, timeout 8, step 4). A rail model
// returns PGOOD two clocks after each enable unless the rail is forced bad.
module tb_power_sequencer;
  import power_seq_pkg::*;

  localparam int unsigned N = 5;

  logic         clk = 1'b0;
  logic         rst_n, start, clear, temp;
  logic [N-1:0] pgood, en, fail_mask;
  logic         prog_b, fault;
  logic [2:0]   state_o;
  logic [1:0]   code;
  logic [3:0]   rail;
  logic [N-1:0] pipe1 = '0;
  logic [N-1:0] pipe2 = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string        name;
    int unsigned  ncyc;
    logic         rst_n, start, clear, temp;
    logic [N-1:0] fail;
    logic [2:0]   st;
    logic [N-1:0] en;
    logic         prog, flt;
    logic [1:0]   code;
    logic [3:0]   rail;
  } vec_t;

  typedef struct packed {
    logic [2:0]   st;
    logic [N-1:0] en;
    logic         prog;
    logic         flt;
    logic [1:0]   code;
    logic [3:0]   rail;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  power_sequencer #(
    .C_RAIL_QTY  (N),
    .C_PG_TIMEOUT(8),
    .C_STEP_DELAY(4)
  ) dut (
    .CLK_IN         (clk),
    .RST_N_IN       (rst_n),
    .START_IN       (start),
    .CLEAR_IN       (clear),
    .TEMP_ALARM_IN  (temp),
    .PGOOD_bus_IN   (pgood),
    .EN_bus_OUT     (en),
    .FPGA_PROG_B_OUT(prog_b),
    .STATE_OUT      (state_o),
    .FAULT_OUT      (fault),
    .FAULT_CODE_OUT (code),
    .FAULT_RAIL_OUT (rail)
  );

  always #5 clk = ~clk;

  // Rail model: power good follows enable by two clocks.
  always @(posedge clk) begin
    pipe1 <= en;
    pipe2 <= pipe1;
  end
  assign pgood = pipe2 & ~fail_mask;

  function automatic vec_t mk(input string nm, input int unsigned n,
                              input logic r, input logic s, input logic c,
                              input logic t, input logic [N-1:0] f,
                              input seq_state_t st, input logic [N-1:0] e,
                              input logic p, input logic fl,
                              input logic [1:0] cd, input logic [3:0] rl);
    vec_t v;
    v.name = nm; v.ncyc = n;
    v.rst_n = r; v.start = s; v.clear = c; v.temp = t; v.fail = f;
    v.st = st; v.en = e; v.prog = p; v.flt = fl; v.code = cd; v.rail = rl;
    return v;
  endfunction

  task automatic check_out();
    obs_t  exp, act;
    string nm;
    act = {state_o, en, prog_b, fault, code, rail};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got st=%0d en=%b, nothing expected", act.st, act.en);
    end else begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got st=%0d en=%b prog=%b flt=%b code=%0d rail=%0d, want st=%0d en=%b prog=%b flt=%b code=%0d rail=%0d",
                 nm, act.st, act.en, act.prog, act.flt, act.code, act.rail,
                 exp.st, exp.en, exp.prog, exp.flt, exp.code, exp.rail);
      end
    end
  endtask

  // Drive a record's inputs, hold them for ncyc edges, then compare.
  task automatic apply(input vec_t v);
    rst_n     = v.rst_n;
    start     = v.start;
    clear     = v.clear;
    temp      = v.temp;
    fail_mask = v.fail;
    exp_q.push_back({v.st, v.en, v.prog, v.flt, v.code, v.rail});
    name_q.push_back(v.name);
    repeat (v.ncyc) @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; temp = 1'b0; fail_mask = '0;

    //                name            n  rst st cl tp fail      state       en       pg fl cd rl
    vecs.push_back(mk("reset",         3, 0, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("idle_hold",     2, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    // full power-up
    vecs.push_back(mk("up_r0_en",      1, 1, 1, 0, 0, 5'b00000, S_WAIT_PG,  5'b00001, 0, 0, 0, 0));
    vecs.push_back(mk("up_r0_settle",  3, 1, 1, 0, 0, 5'b00000, S_SETTLE,   5'b00001, 0, 0, 0, 0));
    vecs.push_back(mk("up_r1_en",      4, 1, 1, 0, 0, 5'b00000, S_WAIT_PG,  5'b00011, 0, 0, 0, 0));
    vecs.push_back(mk("up_r2_en",      7, 1, 1, 0, 0, 5'b00000, S_WAIT_PG,  5'b00111, 0, 0, 0, 0));
    vecs.push_back(mk("up_r3_en",      7, 1, 1, 0, 0, 5'b00000, S_WAIT_PG,  5'b01111, 0, 0, 0, 0));
    vecs.push_back(mk("up_r4_en",      7, 1, 1, 0, 0, 5'b00000, S_WAIT_PG,  5'b11111, 0, 0, 0, 0));
    vecs.push_back(mk("up_r4_settle",  3, 1, 1, 0, 0, 5'b00000, S_SETTLE,   5'b11111, 0, 0, 0, 0));
    vecs.push_back(mk("up_settle_end", 3, 1, 1, 0, 0, 5'b00000, S_SETTLE,   5'b11111, 0, 0, 0, 0));
    vecs.push_back(mk("up_run",        1, 1, 1, 0, 0, 5'b00000, S_RUN,      5'b11111, 1, 0, 0, 0));
    vecs.push_back(mk("run_hold",      5, 1, 1, 0, 0, 5'b00000, S_RUN,      5'b11111, 1, 0, 0, 0));
    // orderly power-down
    vecs.push_back(mk("dn_entry",      1, 1, 0, 0, 0, 5'b00000, S_SHUTDOWN, 5'b01111, 0, 0, 0, 0));
    vecs.push_back(mk("dn_hold",       3, 1, 0, 0, 0, 5'b00000, S_SHUTDOWN, 5'b01111, 0, 0, 0, 0));
    vecs.push_back(mk("dn_step1",      1, 1, 0, 0, 0, 5'b00000, S_SHUTDOWN, 5'b00111, 0, 0, 0, 0));
    vecs.push_back(mk("dn_all_off",   12, 1, 0, 0, 0, 5'b00000, S_SHUTDOWN, 5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("dn_idle",       1, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("idle_flush",    3, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    // PGOOD timeout on rail 2
    vecs.push_back(mk("to_r0",         1, 1, 1, 0, 0, 5'b00100, S_WAIT_PG,  5'b00001, 0, 0, 0, 0));
    vecs.push_back(mk("to_r2_en",     14, 1, 1, 0, 0, 5'b00100, S_WAIT_PG,  5'b00111, 0, 0, 0, 0));
    vecs.push_back(mk("to_pre",        7, 1, 1, 0, 0, 5'b00100, S_WAIT_PG,  5'b00111, 0, 0, 0, 0));
    vecs.push_back(mk("to_trip",       1, 1, 1, 0, 0, 5'b00100, S_SHUTDOWN, 5'b00011, 0, 1, 1, 2));
    vecs.push_back(mk("to_hold",       3, 1, 1, 0, 0, 5'b00100, S_SHUTDOWN, 5'b00011, 0, 1, 1, 2));
    vecs.push_back(mk("to_step",       1, 1, 1, 0, 0, 5'b00100, S_SHUTDOWN, 5'b00001, 0, 1, 1, 2));
    vecs.push_back(mk("to_off",        4, 1, 1, 0, 0, 5'b00100, S_SHUTDOWN, 5'b00000, 0, 1, 1, 2));
    vecs.push_back(mk("to_fault",      1, 1, 1, 0, 0, 5'b00100, S_FAULT,    5'b00000, 0, 1, 1, 2));
    vecs.push_back(mk("fault_start",   5, 1, 1, 0, 0, 5'b00100, S_FAULT,    5'b00000, 0, 1, 1, 2));
    vecs.push_back(mk("fault_clear",   1, 1, 0, 1, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("idle_flush2",   3, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    // PGOOD loss and over-temp in the same cycle: loss wins
    vecs.push_back(mk("lt_run",       36, 1, 1, 0, 0, 5'b00000, S_RUN,      5'b11111, 1, 0, 0, 0));
    vecs.push_back(mk("lt_trip",       1, 1, 1, 0, 1, 5'b01000, S_SHUTDOWN, 5'b01111, 0, 1, 2, 3));
    vecs.push_back(mk("lt_fault",     17, 1, 1, 0, 1, 5'b01000, S_FAULT,    5'b00000, 0, 1, 2, 3));
    vecs.push_back(mk("lt_clear",      1, 1, 0, 1, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("idle_flush3",   3, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    // two rails lost together: lowest index reported
    vecs.push_back(mk("ll_run",       36, 1, 1, 0, 0, 5'b00000, S_RUN,      5'b11111, 1, 0, 0, 0));
    vecs.push_back(mk("ll_trip",       1, 1, 1, 0, 0, 5'b01010, S_SHUTDOWN, 5'b01111, 0, 1, 2, 1));
    vecs.push_back(mk("ll_fault",     17, 1, 1, 0, 0, 5'b01010, S_FAULT,    5'b00000, 0, 1, 2, 1));
    vecs.push_back(mk("ll_clear",      1, 1, 0, 1, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("idle_flush4",   3, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    // over-temperature in RUN
    vecs.push_back(mk("tp_run",       36, 1, 1, 0, 0, 5'b00000, S_RUN,      5'b11111, 1, 0, 0, 0));
`ifdef POWER_SEQ_TEMP_SHUTDOWN_EN
    vecs.push_back(mk("tp_trip",       1, 1, 1, 0, 1, 5'b00000, S_SHUTDOWN, 5'b01111, 0, 1, 3, 0));
    vecs.push_back(mk("tp_fault",     17, 1, 1, 0, 1, 5'b00000, S_FAULT,    5'b00000, 0, 1, 3, 0));
    vecs.push_back(mk("tp_clear",      1, 1, 0, 1, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
`else
    vecs.push_back(mk("tp_ignored",    1, 1, 1, 0, 1, 5'b00000, S_RUN,      5'b11111, 1, 0, 0, 0));
    vecs.push_back(mk("tp_ign_hold",  17, 1, 1, 0, 1, 5'b00000, S_RUN,      5'b11111, 1, 0, 0, 0));
    vecs.push_back(mk("tp_down",      18, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
`endif
    vecs.push_back(mk("idle_flush5",   3, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    // reset asserted during SETTLE of rail 1
    vecs.push_back(mk("rs_r0",         1, 1, 1, 0, 0, 5'b00000, S_WAIT_PG,  5'b00001, 0, 0, 0, 0));
    vecs.push_back(mk("rs_settle1",   10, 1, 1, 0, 0, 5'b00000, S_SETTLE,   5'b00011, 0, 0, 0, 0));
    vecs.push_back(mk("rs_reset",      1, 0, 1, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("rs_release",    1, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));
    vecs.push_back(mk("idle_flush6",   3, 1, 0, 0, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Loss of rail 0 on the very cycle rail 1 times out: loss has priority.
    apply(mk("pr_r0",    1, 1, 1, 0, 0, 5'b00010, S_WAIT_PG,  5'b00001, 0, 0, 0, 0));
    apply(mk("pr_r1",   14, 1, 1, 0, 0, 5'b00010, S_WAIT_PG,  5'b00011, 0, 0, 0, 0));
    apply(mk("pr_trip",  1, 1, 1, 0, 0, 5'b00011, S_SHUTDOWN, 5'b00001, 0, 1, 2, 0));
    apply(mk("pr_fault", 5, 1, 1, 0, 0, 5'b00011, S_FAULT,    5'b00000, 0, 1, 2, 0));
    apply(mk("pr_clear", 1, 1, 0, 1, 0, 5'b00000, S_IDLE,     5'b00000, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
